// File: rtl/mips_exec_mem_unit.sv
// Execute/memory slice of a single-cycle MIPS datapath:
// control decode, ALU, word-addressed data memory and write-back mux.
module mips_exec_mem_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] extend32,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        branch,
  output logic [1:0]  ALUOperation,
  output logic [31:0] alu_b,
  output logic [31:0] alu_out,
  output logic        Zero,
  output logic        branch_taken,
  output logic [31:0] MemReadData,
  output logic [31:0] WriteDataReg
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  logic [5:0]    opcode;
  logic [5:0]    func;
  logic          rw_raw;
  logic          mw_raw;
  logic          br_raw;
  logic [AW-1:0] idx;
  logic [31:0]   mem_q [MEM_WORDS];
  logic          unused_bits;

  assign opcode = Instruction[31:26];
  assign func   = Instruction[5:0];

  always_comb begin
    RegDst       = 1'b0;
    rw_raw       = 1'b0;
    MemToReg     = 1'b0;
    ALUSrc       = 1'b0;
    MemRead      = 1'b0;
    mw_raw       = 1'b0;
    br_raw       = 1'b0;
    ALUOperation = 2'b00;
    unique case (opcode)
      OP_R: begin
        RegDst = 1'b1;
        rw_raw = 1'b1;
        unique case (func)
          FN_ADD:  ALUOperation = 2'b00;
          FN_SUB:  ALUOperation = 2'b01;
          FN_AND:  ALUOperation = 2'b10;
          FN_OR:   ALUOperation = 2'b11;
          default: rw_raw = 1'b0;
        endcase
      end
      OP_LW: begin
        ALUSrc   = 1'b1;
        MemToReg = 1'b1;
        MemRead  = 1'b1;
        rw_raw   = 1'b1;
      end
      OP_SW: begin
        ALUSrc = 1'b1;
        mw_raw = 1'b1;
      end
      OP_BEQ: begin
        br_raw       = 1'b1;
        ALUOperation = 2'b01;
      end
      OP_ADDI: begin
        ALUSrc = 1'b1;
        rw_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Side-effecting controls are suppressed while reset is held.
  assign RegWrite     = rw_raw & rst;
  assign MemWrite     = mw_raw & rst;
  assign branch       = br_raw & rst;
  assign branch_taken = branch & Zero;

  assign alu_b = ALUSrc ? extend32 : ReadData2;

  always_comb begin
    alu_out = '0;
    unique case (ALUOperation)
      2'b00: alu_out = ReadData1 + alu_b;
      2'b01: alu_out = ReadData1 - alu_b;
      2'b10: alu_out = ReadData1 & alu_b;
      2'b11: alu_out = ReadData1 | alu_b;
      default: alu_out = '0;
    endcase
  end

  assign Zero = (alu_out == 32'h0);

  assign idx         = alu_out[AW+1:2];
  assign MemReadData = mem_q[idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (MemWrite) begin
      mem_q[idx] <= ReadData2;
    end
  end

  assign WriteDataReg = MemToReg ? MemReadData : alu_out;

  assign unused_bits = ^{Instruction[25:6], alu_out[31:AW+2], alu_out[1:0]};

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Directed and random checks of mips_exec_mem_unit against
// a behavioural model of the execute/memory slice.
module tb_mips_exec_mem_unit;

  localparam int MW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instruction, ReadData1, ReadData2, extend32;
  logic        RegDst, RegWrite, MemToReg, ALUSrc;
  logic        MemRead, MemWrite, branch;
  logic [1:0]  ALUOperation;
  logic [31:0] alu_b, alu_out;
  logic        Zero, branch_taken;
  logic [31:0] MemReadData, WriteDataReg;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] model_mem [MW];
  logic        exp_we;
  int          exp_idx;

  mips_exec_mem_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .Instruction(Instruction),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .extend32(extend32),
    .RegDst(RegDst), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .ALUSrc(ALUSrc),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .branch(branch), .ALUOperation(ALUOperation),
    .alu_b(alu_b), .alu_out(alu_out),
    .Zero(Zero), .branch_taken(branch_taken),
    .MemReadData(MemReadData),
    .WriteDataReg(WriteDataReg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 20'h0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 26'h0};
  endfunction

  // Expected behaviour derived from the instruction semantics.
  task automatic model_check();
    logic [5:0]  op, fn;
    logic        rd, rw, m2r, as, mr, mw, br;
    logic [1:0]  aop;
    logic [31:0] b, r, rdm;
    op = Instruction[31:26];
    fn = Instruction[5:0];
    {rd, rw, m2r, as, mr, mw, br} = '0;
    aop = 2'b00;
    if (op == 6'd0) begin
      rd = 1;
      rw = 1;
      if (fn == 6'h20) aop = 2'd0;
      else if (fn == 6'h22) aop = 2'd1;
      else if (fn == 6'h24) aop = 2'd2;
      else if (fn == 6'h25) aop = 2'd3;
      else rw = 0;
    end else if (op == 6'h23) begin
      as = 1; m2r = 1; mr = 1; rw = 1;
    end else if (op == 6'h2b) begin
      as = 1; mw = 1;
    end else if (op == 6'h04) begin
      br = 1; aop = 2'd1;
    end else if (op == 6'h08) begin
      as = 1; rw = 1;
    end
    if (!rst) begin
      rw = 0; mw = 0; br = 0;
    end
    b = as ? extend32 : ReadData2;
    if (aop == 2'd0) r = ReadData1 + b;
    else if (aop == 2'd1) r = ReadData1 - b;
    else if (aop == 2'd2) r = ReadData1 & b;
    else r = ReadData1 | b;
    exp_idx = int'((r / 4) % MW);
    exp_we  = mw;
    rdm = model_mem[exp_idx];
    chk("ctrl",
        {23'h0, RegDst, RegWrite, MemToReg, ALUSrc,
         MemRead, MemWrite, branch, ALUOperation},
        {23'h0, rd, rw, m2r, as, mr, mw, br, aop});
    chk("alu_b", alu_b, b);
    chk("alu_out", alu_out, r);
    chk("zero", {31'h0, Zero}, {31'h0, r == 0});
    chk("taken", {31'h0, branch_taken}, {31'h0, br && r == 0});
    chk("memrd", MemReadData, rdm);
    chk("wb", WriteDataReg, m2r ? rdm : r);
  endtask

  task automatic drive(input logic [31:0] ins, a, bb, e,
                       input logic r);
    @(negedge clk);
    Instruction = ins;
    ReadData1   = a;
    ReadData2   = bb;
    extend32    = e;
    rst         = r;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < MW; i++) model_mem[i] = '0;
    end else if (exp_we) begin
      model_mem[exp_idx] = ReadData2;
    end
  endtask

  initial begin
    logic [31:0] ins, a, bb, e, rnd;
    logic [5:0]  op, fn;
    logic        rv;
    int          k;
    logic [5:0]  fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h2a;

    // Reset with arbitrary stale inputs; memory becomes all-zero.
    for (int i = 0; i < MW; i++) model_mem[i] = '0;
    Instruction = '0; ReadData1 = '0;
    ReadData2 = '0; extend32 = '0;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);

    drive(itype(6'h23), 0, 0, 8, 1'b1);
    chk("rst_lw_rd", MemReadData, 32'h0);
    chk("rst_lw_rw", {31'h0, RegWrite}, 32'h1);
    tick();

    drive(rtype(6'h20), 7, 5, 0, 1'b1);
    chk("add", alu_out, 32'd12);
    chk("add_rdst", {31'h0, RegDst}, 32'h1);
    tick();
    drive(rtype(6'h22), 5, 7, 0, 1'b1);
    chk("sub", alu_out, 32'hFFFF_FFFE);
    tick();
    drive(rtype(6'h24), 32'hF0F0, 32'h0FF0, 0, 1'b1);
    chk("and", alu_out, 32'h0000_00F0);
    tick();
    drive(rtype(6'h25), 32'hF0F0, 32'h0FF0, 0, 1'b1);
    chk("or", alu_out, 32'h0000_FFF0);
    tick();

    drive(itype(6'h2b), 4, 32'hDEAD_BEEF, 4, 1'b1);
    chk("sw_old", MemReadData, 32'h0);
    tick();
    drive(itype(6'h23), 4, 0, 4, 1'b1);
    chk("lw_new", MemReadData, 32'hDEAD_BEEF);
    tick();
    drive(itype(6'h23), 6, 0, 4, 1'b1);
    chk("lw_lowbits", MemReadData, 32'hDEAD_BEEF);
    tick();
    drive(itype(6'h23), 8 + 4 * MW, 0, 0, 1'b1);
    chk("lw_alias", MemReadData, 32'hDEAD_BEEF);
    tick();

    drive(itype(6'h04), 32'h1234, 32'h1234, 0, 1'b1);
    chk("beq_taken", {31'h0, branch_taken}, 32'h1);
    tick();
    drive(itype(6'h04), 32'h1234, 32'h1235, 0, 1'b1);
    chk("beq_not", {31'h0, branch_taken}, 32'h0);
    tick();

    drive(itype(6'h08), 32'hFFFF_FFFF, 0, 1, 1'b1);
    chk("addi_wrap", alu_out, 32'h0);
    tick();

    drive(itype(6'h3f), 4, 32'h5555_AAAA, 4, 1'b1);
    tick();
    drive(itype(6'h23), 4, 0, 4, 1'b1);
    chk("bad_op_nowr", MemReadData, 32'hDEAD_BEEF);
    tick();

    drive(itype(6'h2b), 4, 32'h1111_2222, 4, 1'b0);
    chk("rst_sw_mw", {31'h0, MemWrite}, 32'h0);
    tick();
    drive(itype(6'h23), 4, 0, 4, 1'b1);
    chk("rst_sw_clr", MemReadData, 32'h0);
    tick();

    // Random mix with small addresses so loads hit prior stores.
    for (int n = 0; n < 400; n++) begin
      k   = $urandom_range(0, 9);
      rnd = $urandom();
      a   = $urandom_range(0, 255);
      e   = $urandom_range(0, 255);
      bb  = $urandom();
      fn  = fns[$urandom_range(0, 4)];
      rv  = ($urandom_range(0, 24) != 0);
      unique case (k)
        0, 1, 2, 3: op = 6'h00;
        4, 5: op = 6'h23;
        6: op = 6'h2b;
        7: op = 6'h04;
        8: op = 6'h08;
        default: op = rnd[5:0];
      endcase
      if (k == 3) begin
        a  = $urandom();
        fn = rnd[31:26];
      end
      if (k == 7 && rnd[0]) bb = a;
      ins = {op, rnd[25:6], fn};
      drive(ins, a, bb, e, rv);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
